// File: rtl/johnson_seq_ctrl.sv
// Gated Johnson-counter sequencer: runs a requested number of steps in either direction with start/busy/done, hold and abort.
// Optional preload of a legal Johnson code while idle is enabled by defining JSEQ_PRELOAD_EN.
module johnson_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [CNT_W-1:0]   steps,
    input  logic               dir,
    input  logic               hold,
    input  logic               abort,
`ifdef JSEQ_PRELOAD_EN
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
`endif
    output logic [WIDTH-1:0]   Q,
    output logic [2*WIDTH-1:0] phase,
    output logic               busy,
    output logic               done,
    output logic               err
);
    localparam int KW = $clog2(2*WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               dir_q, dir_d;
    logic               err_q, err_d;
    logic               busy_q, done_q;
    logic [WIDTH-1:0]   q_fwd, q_rev;
    logic [KW-1:0]      pop, k;

    assign q_fwd = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
    assign q_rev = {~q_q[0], q_q[WIDTH-1:1]};

`ifdef JSEQ_PRELOAD_EN
    // Legal codes are a run of ones hugging bit 0 or hugging the MSB (covers all-zeros and all-ones).
    logic [WIDTH-1:0] inv_val;
    logic             load_legal;
    assign inv_val    = ~load_val;
    assign load_legal = ((load_val & (load_val + WIDTH'(1))) == '0) ||
                        ((inv_val  & (inv_val  + WIDTH'(1))) == '0);
`endif

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (steps != '0) begin
                        rem_d   = steps;
                        dir_d   = dir;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
`ifdef JSEQ_PRELOAD_EN
                else if (load) begin
                    q_d   = load_legal ? load_val : '0;
                    err_d = ~load_legal;
                end
`endif
            end
            RUN: begin
                if (abort) begin
                    state_d = DONE;
                end else if (hold) begin
                    state_d = PAUSE;
                end else begin
                    q_d   = dir_q ? q_rev : q_fwd;
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) state_d = DONE;
                end
            end
            PAUSE: begin
                if (abort)      state_d = DONE;
                else if (!hold) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            q_q     <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
            busy_q  <= (state_d == RUN) || (state_d == PAUSE);
            done_q  <= (state_d == DONE);
        end
    end

    // Phase index: ones count while filling, 2*WIDTH minus ones count while draining.
    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) pop = pop + KW'(q_q[i]);
        k = q_q[WIDTH-1] ? (KW'(2*WIDTH) - pop) : pop;
    end

    assign phase = (2*WIDTH)'(1) << k;
    assign Q     = q_q;
    assign busy  = busy_q;
    assign done  = done_q;
`ifdef JSEQ_PRELOAD_EN
    assign err   = err_q;
`else
    assign err   = 1'b0;
`endif

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Directed bench for johnson_seq_ctrl (WIDTH=4, CNT_W=8); preload steps run when JSEQ_PRELOAD_EN is defined.
module tb_johnson_seq_ctrl;
    logic       clk = 1'b0;
    logic       clr, start, dir, hold, abort;
    logic [7:0] steps;
    logic [3:0] Q;
    logic [7:0] phase;
    logic       busy, done, err;
`ifdef JSEQ_PRELOAD_EN
    logic       load;
    logic [3:0] load_val;
`endif
    int total = 0;
    int bad   = 0;
    int npulse;

    always #5 clk = ~clk;

    johnson_seq_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .clr(clr), .start(start), .steps(steps), .dir(dir),
        .hold(hold), .abort(abort),
`ifdef JSEQ_PRELOAD_EN
        .load(load), .load_val(load_val),
`endif
        .Q(Q), .phase(phase), .busy(busy), .done(done), .err(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [3:0] eq, input logic eb, input logic ed);
        chk({tag, ".Q"}, 32'(Q), 32'(eq));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".done"}, 32'(done), 32'(ed));
    endtask

    task automatic do_clr();
        clr = 1'b1; tick(); clr = 1'b0;
    endtask

    task automatic go(input logic [7:0] n, input logic d);
        start = 1'b1; steps = n; dir = d; tick(); start = 1'b0;
    endtask

    initial begin
        logic [3:0] exp5 [5];
        logic [3:0] exp6 [4];
        exp5 = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110};
        exp6 = '{4'b0111, 4'b1111, 4'b1110, 4'b1100};
        clr = 1'b0; start = 1'b0; steps = '0; dir = 1'b0; hold = 1'b0; abort = 1'b0;
`ifdef JSEQ_PRELOAD_EN
        load = 1'b0; load_val = '0;
`endif
        tick();
        do_clr();
        chk_st("reset", 4'b0000, 1'b0, 1'b0);
        chk("reset.phase", 32'(phase), 32'h01);
        chk("reset.err", 32'(err), 32'(0));

        // Forward run of 5 steps
        go(8'd5, 1'b0);
        chk_st("fwd5.accept", 4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_st($sformatf("fwd5.s%0d", i+1), exp5[i], i < 4, i == 4);
        end
        chk("fwd5.phase", 32'(phase), 32'h20);
        tick();
        chk_st("fwd5.idle", 4'b1110, 1'b0, 1'b0);

        // Reverse 3 from zero, then forward 10 wrapping
        do_clr();
        go(8'd3, 1'b1);
        tick(); chk("rev.s1", 32'(Q), 32'b1000);
        tick(); chk("rev.s2", 32'(Q), 32'b1100);
        tick(); chk_st("rev.s3", 4'b1110, 1'b0, 1'b1);
        tick();
        go(8'd10, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        chk_st("wrap.end", 4'b1000, 1'b0, 1'b1);
        chk("wrap.phase", 32'(phase), 32'h80);
        tick();

        // Hold for 3 cycles after the 2nd step
        do_clr();
        npulse = 0;
        go(8'd6, 1'b0);
        tick(); tick();
        chk("hold.pre", 32'(Q), 32'b0011);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_st($sformatf("hold.p%0d", i), 4'b0011, 1'b1, 1'b0);
        end
        hold = 1'b0;
        tick();
        chk_st("hold.bubble", 4'b0011, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("hold.s%0d", i+3), 32'(Q), 32'(exp6[i]));
            if (done) npulse++;
        end
        tick();
        if (done) npulse++;
        chk("hold.npulse", 32'(npulse), 32'(1));
        chk_st("hold.idle", 4'b1100, 1'b0, 1'b0);

        // Abort after 3rd step; start during DONE ignored
        do_clr();
        go(8'd8, 1'b0);
        tick(); tick(); tick();
        chk("abort.pre", 32'(Q), 32'b0111);
        abort = 1'b1; tick(); abort = 1'b0;
        chk_st("abort.done", 4'b0111, 1'b0, 1'b1);
        start = 1'b1; steps = 8'd4; tick(); start = 1'b0;
        chk_st("abort.idle", 4'b0111, 1'b0, 1'b0);
        tick();
        chk_st("abort.noqueue", 4'b0111, 1'b0, 1'b0);

        // Zero-step start
        go(8'd0, 1'b0);
        chk_st("zero.done", 4'b0111, 1'b0, 1'b1);
        tick();
        chk_st("zero.idle", 4'b0111, 1'b0, 1'b0);

        // start while busy ignored; mid-run steps/dir changes ignored
        go(8'd2, 1'b0);
        start = 1'b1; steps = 8'd7; dir = 1'b1; tick(); start = 1'b0;
        chk_st("busy.s1", 4'b1111, 1'b1, 1'b0);
        tick();
        chk_st("busy.s2", 4'b1110, 1'b0, 1'b1);
        tick();
        chk_st("busy.idle", 4'b1110, 1'b0, 1'b0);

        // clr mid-run
        do_clr();
        go(8'd8, 1'b0);
        tick(); tick();
        chk("clr.pre", 32'(Q), 32'b0011);
        clr = 1'b1; tick(); clr = 1'b0;
        chk_st("clr.hit", 4'b0000, 1'b0, 1'b0);
        tick();
        chk_st("clr.after", 4'b0000, 1'b0, 1'b0);

`ifdef JSEQ_PRELOAD_EN
        load = 1'b1; load_val = 4'b1100; tick(); load = 1'b0;
        chk("pre.q", 32'(Q), 32'b1100);
        chk("pre.err", 32'(err), 32'(0));
        load = 1'b1; load_val = 4'b0101; tick(); load = 1'b0;
        chk("pre.badq", 32'(Q), 32'b0000);
        chk("pre.baderr", 32'(err), 32'(1));
        tick();
        chk("pre.sticky", 32'(err), 32'(1));
        go(8'd1, 1'b0);
        chk("pre.clrerr", 32'(err), 32'(0));
        tick();
        chk_st("pre.step", 4'b0001, 1'b0, 1'b1);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
